// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with one-hot registered grant,
// owner release on done/request drop, and an optional MAX_HOLD tenure limit.
module rr_arbiter16 #(
  parameter logic [7:0] MAX_HOLD = 8'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t      r_state, w_state_nx;
  logic [3:0]  r_ptr, r_idx, w_win;
  logic [7:0]  r_hold, w_hold_nx;
  logic        r_tmo, r_live, w_lim, w_drop, w_rel;
  // Descending scan so the lowest offset from ptr+1 wins last.
  always_comb begin
    w_win = r_ptr;
    for (int i = 16; i >= 1; i--)
      if (req[r_ptr + 4'(i)]) w_win = r_ptr + 4'(i);
  end
  assign w_hold_nx = r_hold + 8'd1;
  assign w_lim     = (MAX_HOLD != 8'd0) && (w_hold_nx == MAX_HOLD);
  assign w_drop    = !req[r_idx];
  assign w_rel     = done || w_drop || w_lim;
  // r_live holds off arbitration for the first edge after reset release.
  always_comb begin
    w_state_nx = r_state;
    if (r_state == IDLE) w_state_nx = (r_live && |req) ? GRANT : IDLE;
    else                 w_state_nx = w_rel ? IDLE : GRANT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 4'd15;
      r_idx   <= 4'd0;
      r_hold  <= 8'd0;
      r_tmo   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nx;
      r_tmo   <= (r_state == GRANT) && w_lim && !done && !w_drop;
      if (r_state == IDLE && w_state_nx == GRANT) begin
        r_idx  <= w_win;
        r_ptr  <= w_win;
        r_hold <= 8'd0;
      end else if (r_state == GRANT) begin
        r_hold <= w_hold_nx;
      end
    end
  end
  assign gnt       = (r_state == GRANT) ? (16'd1 << r_idx) : 16'd0;
  assign gnt_idx   = r_idx;
  assign gnt_valid = (r_state == GRANT);
  assign timeout   = r_tmo;
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: scoreboard bench; a cycle-level reference model pushes
// expected outputs per edge and a monitor compares them on the falling edge.
module tb_rr_arbiter16;
  localparam logic [7:0] MH = 8'd4;
  logic        clk = 1'b0, rst_n = 1'b0, done = 1'b0;
  logic [15:0] req = 16'd0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid, timeout;
  int          checks = 0, errors = 0;
  logic [21:0] q[$];

  always #5 clk = ~clk;

  rr_arbiter16 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  // Reference model: owner -1 means nobody holds the resource.
  initial begin
    int owner, ptr, last, held;
    bit armed, tmo, lim;
    owner = -1; ptr = 15; last = 0; held = 0; armed = 0; tmo = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        owner = -1; ptr = 15; last = 0; held = 0; armed = 0; tmo = 0;
      end else if (!armed) begin
        armed = 1; tmo = 0;
      end else if (owner < 0) begin
        tmo = 0;
        for (int k = 1; k <= 16; k++) begin
          int c;
          c = (ptr + k) % 16;
          if (owner < 0 && req[c]) begin
            owner = c; ptr = c; last = c; held = 1;
          end
        end
      end else begin
        lim = (MH != 0) && (held == int'(MH));
        if (done || !req[owner] || lim) begin
          tmo = lim && !done && req[owner];
          owner = -1;
        end else begin
          held++;
          tmo = 0;
        end
      end
      q.push_back({(owner >= 0) ? (16'd1 << owner) : 16'd0, 4'(last), owner >= 0, tmo});
    end
  end

  initial begin
    logic [21:0] e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!rst_n) e = 22'd0;
        a = {gnt, gnt_idx, gnt_valid, timeout};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_check t=%0t got gnt=%h idx=%0d v=%b to=%b exp gnt=%h idx=%0d v=%b to=%b",
                   $time, a[21:6], a[5:2], a[1], a[0], e[21:6], e[5:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic cyc(input logic [15:0] r, input logic d, input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
      req = r;
      done = d;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(16'h8001, 1'b1, 10);
    cyc(16'h0000, 1'b0, 2);
    cyc(16'hFFFF, 1'b1, 40);
    cyc(16'h0000, 1'b0, 2);
    cyc(16'h0010, 1'b0, 14);
    cyc(16'h0000, 1'b0, 2);
    cyc(16'h0008, 1'b0, 3);
    cyc(16'h0080, 1'b0, 6);
    cyc(16'h0000, 1'b0, 2);
    cyc(16'h0001, 1'b0, 4);
    cyc(16'h0001, 1'b1, 1);
    cyc(16'h0000, 1'b0, 3);
    cyc(16'h0200, 1'b0, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 16'd0 || gnt_idx !== 4'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got gnt=%h idx=%0d v=%b to=%b exp all zero", gnt, gnt_idx, gnt_valid, timeout);
    end
    req = 16'h0201;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(16'h0201, 1'b1, 6);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #3;
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0) req = 16'($urandom & $urandom & $urandom);
      done = ($urandom_range(0, 5) == 0);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #7;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
